// File: rtl/hazard_pkg.sv
// Shared types and helpers for the multi-cycle hazard unit.
// reg_match works on fields zero-padded to a fixed stride so one function serves any width.
package hazard_pkg;

    typedef enum logic {RUN, LOAD_STALL} hz_state_t;

    localparam int unsigned REG_ADDR_W_DEF = 3;
    localparam int unsigned MAX_OPS        = 8;
    localparam int unsigned MAX_ADDR_W     = 8;

    function automatic logic reg_match(input logic [MAX_ADDR_W-1:0]         dest,
                                       input logic [MAX_OPS*MAX_ADDR_W-1:0] ops,
                                       input logic [MAX_OPS-1:0]            valid);
        logic m;
        m = 1'b0;
        for (int i = 0; i < MAX_OPS; i++) begin
            if (valid[i] && ops[i*MAX_ADDR_W +: MAX_ADDR_W] == dest) begin
                m = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side signal bundle of the hazard unit; slave is the hazard unit itself.
interface hazard_unit_mc_if #(
    parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W_DEF,
    parameter int unsigned NUM_OPS    = 2,
    parameter int unsigned CNT_W      = 16
);
    logic                          branch_taken;
    logic                          mem_read_dec;
    logic [REG_ADDR_W-1:0]         r_dest_dec;
    logic [NUM_OPS*REG_ADDR_W-1:0] r_ops_fetch;
    logic [NUM_OPS-1:0]            ops_valid_fetch;
    logic                          mem_busy;
    logic                          flush_fetch;
    logic                          flush_decode;
    logic                          stall_fetch;
    logic                          stall_decode;
    logic                          pc_write;
    logic [CNT_W-1:0]              stall_cycles;

    modport master (
        output branch_taken, mem_read_dec, r_dest_dec, r_ops_fetch, ops_valid_fetch, mem_busy,
        input  flush_fetch, flush_decode, stall_fetch, stall_decode, pc_write, stall_cycles
    );

    modport slave (
        input  branch_taken, mem_read_dec, r_dest_dec, r_ops_fetch, ops_valid_fetch, mem_busy,
        output flush_fetch, flush_decode, stall_fetch, stall_decode, pc_write, stall_cycles
    );
endinterface

// File: rtl/hazard_cmp.sv
// Load-use comparator: decode-stage load destination against every valid fetch-stage field.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_OPS    = 2
) (
    input  logic                          mem_read,
    input  logic [REG_ADDR_W-1:0]         dest,
    input  logic [NUM_OPS*REG_ADDR_W-1:0] ops,
    input  logic [NUM_OPS-1:0]            valid,
    output logic                          hit
);
    logic [MAX_OPS*MAX_ADDR_W-1:0] ops_pad;
    logic [MAX_OPS-1:0]            valid_pad;
    logic [MAX_ADDR_W-1:0]         dest_pad;

    // Unused padded slots stay invalid, so they can never match.
    always_comb begin
        ops_pad   = '0;
        valid_pad = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            ops_pad[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(ops[i*REG_ADDR_W +: REG_ADDR_W]);
            valid_pad[i] = valid[i];
        end
    end

    assign dest_pad = MAX_ADDR_W'(dest);
    assign hit      = mem_read && reg_match(dest_pad, ops_pad, valid_pad);

endmodule

// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard controller: load-use stall with latency, memory-busy freeze,
// branch flush (deferred while memory is busy) and a saturating stall-cycle counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int unsigned NUM_OPS      = 2,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
) (
    input logic             clk,
    input logic             rst_n,
    hazard_unit_mc_if.slave bus
);
    localparam logic [3:0] CNT_INIT = 4'(LOAD_LATENCY - 1);

    hz_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic             hit;
    logic             flush_go;
    logic             flush;
    logic             stall;
    logic             pc_write;

    hazard_cmp #(
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_OPS   (NUM_OPS)
    ) u_cmp (
        .mem_read(bus.mem_read_dec),
        .dest    (bus.r_dest_dec),
        .ops     (bus.r_ops_fetch),
        .valid   (bus.ops_valid_fetch),
        .hit     (hit)
    );

    // A fresh branch and a deferred one are handled identically once memory is free.
    assign flush_go = !bus.mem_busy && (bus.branch_taken || pend_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (bus.mem_busy) begin
            if (bus.branch_taken) pend_d = 1'b1;
        end else if (flush_go) begin
            state_d = RUN;
            cnt_d   = 4'd0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hit && LOAD_LATENCY > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                LOAD_STALL: begin
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        flush    = 1'b0;
        stall    = 1'b0;
        pc_write = 1'b1;
        if (bus.mem_busy) begin
            stall    = 1'b1;
            pc_write = 1'b0;
        end else if (flush_go) begin
            flush = 1'b1;
        end else if (state_q == LOAD_STALL || hit) begin
            stall    = 1'b1;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (!pc_write && stall_cycles_q != '1) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign bus.flush_fetch  = flush;
    assign bus.flush_decode = flush;
    assign bus.stall_fetch  = stall;
    assign bus.stall_decode = stall;
    assign bus.pc_write     = pc_write;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench: two hazard units (latency 3 / 16-bit counter, latency 1 / 4-bit counter)
// share stimulus and are compared against a remaining-stall-cycles reference model.
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_ADDR_W(3), .NUM_OPS(2), .CNT_W(16)) bus_a ();
    hazard_unit_mc_if #(.REG_ADDR_W(3), .NUM_OPS(2), .CNT_W(4))  bus_b ();

    assign bus_b.branch_taken    = bus_a.branch_taken;
    assign bus_b.mem_read_dec    = bus_a.mem_read_dec;
    assign bus_b.r_dest_dec      = bus_a.r_dest_dec;
    assign bus_b.r_ops_fetch     = bus_a.r_ops_fetch;
    assign bus_b.ops_valid_fetch = bus_a.ops_valid_fetch;
    assign bus_b.mem_busy        = bus_a.mem_busy;

    hazard_unit_mc #(.REG_ADDR_W(3), .NUM_OPS(2), .LOAD_LATENCY(3), .CNT_W(16)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a.slave)
    );

    hazard_unit_mc #(.REG_ADDR_W(3), .NUM_OPS(2), .LOAD_LATENCY(1), .CNT_W(4)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: stall cycles still owed, pending flush, stall-cycle tally.
    int rem[2];
    bit pend[2];
    int scnt[2];
    int lat[2]  = '{3, 1};
    int cmax[2] = '{65535, 15};

    int a_low, a_flush;
    bit last_ff, last_fd, last_sf, last_pcw;

    typedef struct {
        bit         br;
        bit         mr;
        logic [2:0] dest;
        logic [5:0] ops;
        logic [1:0] valid;
        bit         busy;
        bit         e_flush;
        bit         e_stall;
        bit         e_pcw;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_in(input bit br, input bit mr, input logic [2:0] dest,
                          input logic [5:0] ops, input logic [1:0] valid, input bit busy);
        bus_a.branch_taken    = br;
        bus_a.mem_read_dec    = mr;
        bus_a.r_dest_dec      = dest;
        bus_a.r_ops_fetch     = ops;
        bus_a.ops_valid_fetch = valid;
        bus_a.mem_busy        = busy;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 3'd0, 6'd0, 2'b00, 1'b0);
    endtask

    // Called at a falling edge: holds reset over one rising edge, releases at the next fall.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rem[k]  = 0;
            pend[k] = 1'b0;
            scnt[k] = 0;
        end
        a_low   = 0;
        a_flush = 0;
    endtask

    // Called at a falling edge with inputs applied; checks both DUTs, advances to next fall.
    task automatic check_cycle(input string tag);
        bit    h, busy, br, ef, es, ep;
        int    fld;
        string s;
        #2;
        busy = bus_a.mem_busy;
        br   = bus_a.branch_taken;
        h    = 1'b0;
        for (int f = 0; f < 2; f++) begin
            fld = (int'(bus_a.r_ops_fetch) >> (3 * f)) & 7;
            if (bus_a.mem_read_dec && bus_a.ops_valid_fetch[f] && fld == int'(bus_a.r_dest_dec))
                h = 1'b1;
        end
        last_ff  = bus_a.flush_fetch;
        last_fd  = bus_a.flush_decode;
        last_sf  = bus_a.stall_fetch;
        last_pcw = bus_a.pc_write;
        if (!bus_a.pc_write) a_low++;
        if (bus_a.flush_fetch) a_flush++;
        for (int k = 0; k < 2; k++) begin
            s = $sformatf("%s.%s", tag, (k == 0) ? "a" : "b");
            if (busy) begin
                ef = 0; es = 1; ep = 0;
            end else if (br || pend[k]) begin
                ef = 1; es = 0; ep = 1;
            end else if (rem[k] > 0 || h) begin
                ef = 0; es = 1; ep = 0;
            end else begin
                ef = 0; es = 0; ep = 1;
            end
            chk({s, ".flush_fetch"}, (k == 0) ? bus_a.flush_fetch : bus_b.flush_fetch, ef);
            chk({s, ".flush_decode"}, (k == 0) ? bus_a.flush_decode : bus_b.flush_decode, ef);
            chk({s, ".stall_fetch"}, (k == 0) ? bus_a.stall_fetch : bus_b.stall_fetch, es);
            chk({s, ".stall_decode"}, (k == 0) ? bus_a.stall_decode : bus_b.stall_decode, es);
            chk({s, ".pc_write"}, (k == 0) ? bus_a.pc_write : bus_b.pc_write, ep);
            chk({s, ".stall_cycles"},
                (k == 0) ? int'(bus_a.stall_cycles) : int'(bus_b.stall_cycles), scnt[k]);
            if (!ep && scnt[k] < cmax[k]) scnt[k]++;
            if (busy) begin
                if (br) pend[k] = 1'b1;
            end else if (br || pend[k]) begin
                pend[k] = 1'b0;
                rem[k]  = 0;
            end else if (rem[k] > 0) begin
                rem[k]--;
            end else if (h) begin
                rem[k] = lat[k] - 1;
            end
        end
        @(negedge clk);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 0, 3'd5, {3'd5, 3'd5}, 2'b11, 0, 0, 0, 1};
        vecs[1]  = '{0, 1, 3'd5, {3'd5, 3'd2}, 2'b11, 0, 0, 1, 0};
        vecs[2]  = '{0, 1, 3'd5, {3'd5, 3'd2}, 2'b01, 0, 0, 0, 1};
        vecs[3]  = '{0, 1, 3'd5, {3'd1, 3'd5}, 2'b01, 0, 0, 1, 0};
        vecs[4]  = '{0, 1, 3'd5, {3'd1, 3'd5}, 2'b10, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 3'd5, {3'd5, 3'd5}, 2'b11, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 3'd5, {3'd5, 3'd2}, 2'b11, 0, 1, 0, 1};
        vecs[7]  = '{0, 0, 3'd0, {3'd0, 3'd0}, 2'b00, 1, 0, 1, 0};
        vecs[8]  = '{1, 0, 3'd0, {3'd0, 3'd0}, 2'b00, 1, 0, 1, 0};
        vecs[9]  = '{0, 1, 3'd0, {3'd0, 3'd0}, 2'b11, 0, 0, 1, 0};
        vecs[10] = '{0, 1, 3'd7, {3'd7, 3'd0}, 2'b10, 0, 0, 1, 0};

        idle();
        @(negedge clk);
        #2;
        chk("reset.pc_write", bus_a.pc_write, 1);
        chk("reset.stall_fetch", bus_a.stall_fetch, 0);
        chk("reset.flush_fetch", bus_a.flush_fetch, 0);
        chk("reset.stall_cycles", int'(bus_a.stall_cycles), 0);
        @(negedge clk);
        do_reset();

        // Single-cycle decode from a freshly reset unit.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_in(vecs[i].br, vecs[i].mr, vecs[i].dest, vecs[i].ops, vecs[i].valid,
                   vecs[i].busy);
            #2;
            chk($sformatf("vec%0d.flush_fetch", i), bus_a.flush_fetch, vecs[i].e_flush);
            chk($sformatf("vec%0d.flush_decode", i), bus_a.flush_decode, vecs[i].e_flush);
            chk($sformatf("vec%0d.stall_fetch", i), bus_a.stall_fetch, vecs[i].e_stall);
            chk($sformatf("vec%0d.stall_decode", i), bus_a.stall_decode, vecs[i].e_stall);
            chk($sformatf("vec%0d.pc_write", i), bus_a.pc_write, vecs[i].e_pcw);
            @(negedge clk);
        end

        // Load-use with latency 3.
        do_reset();
        set_in(0, 1, 3'd5, {3'd5, 3'd2}, 2'b11, 0);
        check_cycle("lu0");
        idle();
        for (int i = 1; i < 6; i++) check_cycle($sformatf("lu%0d", i));
        chk("lu.low_cycles", a_low, 3);
        chk("lu.stall_cycles", int'(bus_a.stall_cycles), 3);

        // Same fields, operand 1 marked invalid.
        do_reset();
        set_in(0, 1, 3'd5, {3'd5, 3'd2}, 2'b01, 0);
        check_cycle("inv0");
        idle();
        check_cycle("inv1");
        chk("inv.low_cycles", a_low, 0);

        // Branch in the second load-stall cycle.
        do_reset();
        set_in(0, 1, 3'd5, {3'd5, 3'd2}, 2'b11, 0);
        check_cycle("bls0");
        set_in(1, 0, 3'd0, 6'd0, 2'b00, 0);
        check_cycle("bls1");
        chk("bls.flush_fetch", last_ff, 1);
        chk("bls.flush_decode", last_fd, 1);
        chk("bls.stall_fetch", last_sf, 0);
        chk("bls.pc_write", last_pcw, 1);
        idle();
        check_cycle("bls2");
        chk("bls.run_pc_write", last_pcw, 1);

        // Branch while memory busy: deferred, merged, single flush.
        do_reset();
        set_in(1, 0, 3'd0, 6'd0, 2'b00, 1);
        check_cycle("df0");
        set_in(0, 0, 3'd0, 6'd0, 2'b00, 1);
        check_cycle("df1");
        set_in(1, 0, 3'd0, 6'd0, 2'b00, 1);
        check_cycle("df2");
        set_in(0, 0, 3'd0, 6'd0, 2'b00, 1);
        check_cycle("df3");
        chk("df.no_flush_busy", a_flush, 0);
        idle();
        check_cycle("df4");
        chk("df.flush_on_free", last_ff, 1);
        check_cycle("df5");
        chk("df.single_flush", a_flush, 1);
        chk("df.stall_cycles", int'(bus_a.stall_cycles), 4);

        // Reset mid-stall.
        do_reset();
        set_in(0, 1, 3'd5, {3'd5, 3'd2}, 2'b11, 0);
        check_cycle("rs0");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs.pc_write", bus_a.pc_write, 1);
        chk("rs.stall_fetch", bus_a.stall_fetch, 0);
        chk("rs.flush_fetch", bus_a.flush_fetch, 0);
        chk("rs.stall_cycles", int'(bus_a.stall_cycles), 0);
        @(negedge clk);
        do_reset();
        check_cycle("rs1");

        // Counter saturation on the 4-bit instance.
        do_reset();
        set_in(0, 0, 3'd0, 6'd0, 2'b00, 1);
        for (int i = 0; i < 20; i++) check_cycle($sformatf("sat%0d", i));
        chk("sat.b_stall_cycles", int'(bus_b.stall_cycles), 15);
        chk("sat.a_stall_cycles", int'(bus_a.stall_cycles), 20);
        for (int i = 0; i < 3; i++) check_cycle($sformatf("sath%0d", i));
        chk("sat.b_hold", int'(bus_b.stall_cycles), 15);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] d, f0, f1;
            d  = 3'($urandom_range(0, 7));
            f0 = ($urandom_range(0, 1) == 1) ? d : 3'($urandom_range(0, 7));
            f1 = ($urandom_range(0, 1) == 1) ? d : 3'($urandom_range(0, 7));
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, d, {f1, f0},
                   2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
            check_cycle($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised, stateful successor to the pipeline hazard controller.
- Detects load-use hazards between the decode-stage load and the fetch-stage instruction's operand fields.
- Holds the stall for a configurable load latency, freezes the front end while data memory is busy, and flushes fetch/decode on taken branches, deferring the flush if memory is busy.
- Sits between the fetch/decode pipeline registers and the PC; it also exports a saturating stall-cycle counter.

Parameters:
- REG_ADDR_W, 3, register-address width.
- NUM_OPS, 2, number of register fields compared in the fetch-stage instruction (sources plus destination).
- LOAD_LATENCY, 1, stall cycles per load-use hazard; legal range is 1 to 15.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch_taken  in  1  branch resolved taken this cycle.
- mem_read_dec  in  1  decode-stage instruction is a load.
- r_dest_dec  in  REG_ADDR_W  destination register of the decode-stage instruction.
- r_ops_fetch  in  NUM_OPS*REG_ADDR_W  fetch-stage register fields; field i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- ops_valid_fetch  in  NUM_OPS  per-field valid; an invalid field never matches.
- mem_busy  in  1  data memory not ready; the whole front end must hold.
- flush_fetch  out  1  clear the fetch/decode register.
- flush_decode  out  1  clear the decode/execute register.
- stall_fetch  out  1  hold the fetch/decode register.
- stall_decode  out  1  insert a NOP into execute.
- pc_write  out  1  PC update enable.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=RUN, cnt=0, flush_pending=0, stall_cycles=0.
  - Outputs: flush_fetch=0, flush_decode=0, stall_fetch=0, stall_decode=0, pc_write=1.
- hit = mem_read_dec and, for any field i, ops_valid_fetch[i] and field i == r_dest_dec. This is a combinational OR over NUM_OPS.
- States: RUN and LOAD_STALL. cnt is 4 bits.
- RUN:
  - If hit, not branch_taken, and not mem_busy: stall_fetch=stall_decode=1 and pc_write=0 in the same cycle.
  - If additionally LOAD_LATENCY>1, go to LOAD_STALL with cnt=LOAD_LATENCY-1; otherwise stay in RUN.
- LOAD_STALL:
  - Stall outputs are asserted and pc_write=0.
  - cnt decrements each cycle in which mem_busy=0; when cnt reaches 1 and mem_busy=0, go to RUN.
  - Total stall length is exactly LOAD_LATENCY cycles when mem_busy stays 0.
- mem_busy=1 (any state):
  - stall_fetch=stall_decode=1, pc_write=0.
  - cnt and state hold.
  - No new hazard detection.
- branch_taken:
  - With mem_busy=0: flush_fetch=flush_decode=1 combinationally in the same cycle.
  - Branch has priority over a hit or LOAD_STALL: stall outputs=0 and pc_write=1 that cycle; state goes to RUN and cnt to 0.
  - With mem_busy=1: set flush_pending and assert no flush.
- flush_pending:
  - In the first cycle with mem_busy=0, assert both flushes, force RUN and clear flush_pending.
  - A second branch_taken while the flush is already pending merges into the same single flush.
- flush_fetch and flush_decode are always equal.
- stall_cycles increments on every cycle with pc_write=0 and saturates at all-ones.
- A reset mid-stall or mid-pending returns immediately to the reset values; no flush is replayed.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum hz_state_t {RUN, LOAD_STALL};
  - the REG_ADDR_W default;
  - the function reg_match(dest, ops, valid) returning hit.
- One natural sub-module, hazard_cmp: the parametrised NUM_OPS comparator producing hit (purely combinational).
- State, counter and pending logic stay in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-LOAD_STALL (LOAD_LATENCY=3) -> outputs immediately reset values; stall_cycles=0; pc_write=1.
- Load-use, LOAD_LATENCY=3: mem_read_dec=1, r_dest_dec=5, field1=5 valid -> pc_write=0 for exactly 3 cycles, then 1; stall_cycles=3.
- Invalid field: same setup as the load-use case but ops_valid_fetch[1]=0 -> no stall; pc_write stays 1.
- Branch during LOAD_STALL: branch_taken=1 in 2nd stall cycle -> flushes=1, stalls=0, pc_write=1 that cycle, RUN next.
- Deferred flush: branch_taken=1 while mem_busy=1 for 4 cycles -> no flush during busy; one flush cycle when mem_busy drops; stall_cycles=4.
- Counter saturation: CNT_W=4, 20 stalled cycles -> stall_cycles=15 and holds.
